// File: rtl/battleship_pkg.sv
// Shared Battleship definitions: key codes, grid geometry and the entry-state
// encoding that the seven-segment display driver also decodes.
package battleship_pkg;

    localparam logic [3:0] KEY_BKSP  = 4'hD;
    localparam logic [3:0] KEY_CLR   = 4'hE;
    localparam logic [3:0] KEY_ENT   = 4'hF;
    localparam logic [3:0] KEY_BLANK = 4'hF;

    localparam int GRID_SIZE_DEF = 8;
    localparam int COORD_W_DEF   = $clog2(GRID_SIZE_DEF);

    typedef enum logic [1:0] {
        ST_WAIT_ROW   = 2'd0,
        ST_WAIT_COL   = 2'd1,
        ST_WAIT_ENTER = 2'd2,
        ST_SEND       = 2'd3
    } entry_state_e;

    // A key is a usable coordinate digit only if it is 0-9 and on the board.
    function automatic logic is_coord_digit(input logic [3:0] key, input int grid);
        return (key <= 4'd9) && (int'(key) < grid);
    endfunction

endpackage

// File: rtl/shot_entry_fsm_idle_timer.sv
// Idle counter for a partial shot entry: cleared by any key activity, runs
// while enabled and pulses expire on its last count.
module idle_timer
    import battleship_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 500_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_r;
    logic             expire_s;

    // Expiry decode from the registered count; clearing activity suppresses it.
    always_comb begin
        expire_s = 1'b0;
        if (en && !clr && (count_r == LAST_COUNT)) begin
            expire_s = 1'b1;
        end else begin
            expire_s = 1'b0;
        end
    end

    assign expire = expire_s;

    // Count register; wraps back to zero after expiring so it reads 0 outside the entry states.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clr || !en || expire_s) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/shot_entry_fsm.sv
// Keypad shot entry: row digit, column digit, ENTER, then offers the
// coordinate to game logic over valid/ready until it is taken.
module shot_entry_fsm
    import battleship_pkg::*;
#(
    parameter int GRID_SIZE      = GRID_SIZE_DEF,
    parameter int TIMEOUT_CYCLES = 500_000_000,
    parameter int COORD_W        = $clog2(GRID_SIZE)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         key_value,
    input  logic               key_valid,
    input  logic               arm,
    input  logic               shot_ready,
    output logic               shot_valid,
    output logic [COORD_W-1:0] shot_row,
    output logic [COORD_W-1:0] shot_col,
    output logic [3:0]         entry_row,
    output logic [3:0]         entry_col,
    output logic [1:0]         entry_stage,
    output logic               key_err
);

    entry_state_e       state_r;
    logic               shot_valid_r;
    logic [COORD_W-1:0] shot_row_r;
    logic [COORD_W-1:0] shot_col_r;
    logic [3:0]         entry_row_r;
    logic [3:0]         entry_col_r;
    logic               key_err_r;

    logic               digit_ok_s;
    logic               timer_en_s;
    logic               timer_clr_s;
    logic               timer_expire_s;

    // Key classification and idle-timer control.
    always_comb begin
        digit_ok_s  = is_coord_digit(key_value, GRID_SIZE);
        timer_en_s  = (state_r == ST_WAIT_COL) || (state_r == ST_WAIT_ENTER);
        timer_clr_s = key_valid || !arm;
    end

    idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr_s),
        .en    (timer_en_s),
        .expire(timer_expire_s)
    );

    // Entry FSM with its registered datapath and outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_WAIT_ROW;
            shot_valid_r <= 1'b0;
            shot_row_r   <= '0;
            shot_col_r   <= '0;
            entry_row_r  <= KEY_BLANK;
            entry_col_r  <= KEY_BLANK;
            key_err_r    <= 1'b0;
        end else begin
            key_err_r <= 1'b0;
            case (state_r)
                ST_SEND: begin
                    // Keys and arm are ignored here; only the handshake ends the offer.
                    if (shot_ready) begin
                        shot_valid_r <= 1'b0;
                        entry_row_r  <= KEY_BLANK;
                        entry_col_r  <= KEY_BLANK;
                        state_r      <= ST_WAIT_ROW;
                    end
                end
                ST_WAIT_ROW, ST_WAIT_COL, ST_WAIT_ENTER: begin
                    if (!arm) begin
                        entry_row_r <= KEY_BLANK;
                        entry_col_r <= KEY_BLANK;
                        state_r     <= ST_WAIT_ROW;
                    end else if (key_valid) begin
                        case (state_r)
                            ST_WAIT_ROW: begin
                                if (digit_ok_s) begin
                                    entry_row_r <= key_value;
                                    state_r     <= ST_WAIT_COL;
                                end else if (key_value != KEY_CLR) begin
                                    key_err_r <= 1'b1;
                                end
                            end
                            ST_WAIT_COL: begin
                                if (digit_ok_s) begin
                                    entry_col_r <= key_value;
                                    state_r     <= ST_WAIT_ENTER;
                                end else if (key_value == KEY_BKSP) begin
                                    entry_row_r <= KEY_BLANK;
                                    state_r     <= ST_WAIT_ROW;
                                end else if (key_value == KEY_CLR) begin
                                    entry_row_r <= KEY_BLANK;
                                    entry_col_r <= KEY_BLANK;
                                    state_r     <= ST_WAIT_ROW;
                                end else begin
                                    key_err_r <= 1'b1;
                                end
                            end
                            ST_WAIT_ENTER: begin
                                if (key_value == KEY_ENT) begin
                                    shot_row_r   <= entry_row_r[COORD_W-1:0];
                                    shot_col_r   <= entry_col_r[COORD_W-1:0];
                                    shot_valid_r <= 1'b1;
                                    state_r      <= ST_SEND;
                                end else if (key_value == KEY_BKSP) begin
                                    entry_col_r <= KEY_BLANK;
                                    state_r     <= ST_WAIT_COL;
                                end else if (key_value == KEY_CLR) begin
                                    entry_row_r <= KEY_BLANK;
                                    entry_col_r <= KEY_BLANK;
                                    state_r     <= ST_WAIT_ROW;
                                end else begin
                                    key_err_r <= 1'b1;
                                end
                            end
                            default: begin
                                state_r <= ST_WAIT_ROW;
                            end
                        endcase
                    end else if (timer_expire_s) begin
                        entry_row_r <= KEY_BLANK;
                        entry_col_r <= KEY_BLANK;
                        state_r     <= ST_WAIT_ROW;
                    end
                end
                default: begin
                    shot_valid_r <= 1'b0;
                    entry_row_r  <= KEY_BLANK;
                    entry_col_r  <= KEY_BLANK;
                    state_r      <= ST_WAIT_ROW;
                end
            endcase
        end
    end

    assign shot_valid  = shot_valid_r;
    assign shot_row    = shot_row_r;
    assign shot_col    = shot_col_r;
    assign entry_row   = entry_row_r;
    assign entry_col   = entry_col_r;
    assign entry_stage = state_r;
    assign key_err     = key_err_r;

endmodule

// File: tb/tb_shot_entry_fsm.sv
// Bench for shot_entry_fsm: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a digit-list model.
module tb_shot_entry_fsm;

    localparam int GRID    = 8;
    localparam int TMO     = 16;
    localparam int CW      = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    key_value = 4'h0;
    logic          key_valid = 1'b0;
    logic          arm = 1'b1;
    logic          shot_ready = 1'b0;
    logic          shot_valid;
    logic [CW-1:0] shot_row;
    logic [CW-1:0] shot_col;
    logic [3:0]    entry_row;
    logic [3:0]    entry_col;
    logic [1:0]    entry_stage;
    logic          key_err;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // Model: typed digits, a sending flag, the committed shot and an idle count.
    int m_digits[$];
    bit m_sending = 1'b0;
    int m_shot_r = 0;
    int m_shot_c = 0;
    bit m_err = 1'b0;
    int m_idle = 0;

    shot_entry_fsm #(
        .GRID_SIZE(GRID),
        .TIMEOUT_CYCLES(TMO),
        .COORD_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_value(key_value),
        .key_valid(key_valid),
        .arm(arm),
        .shot_ready(shot_ready),
        .shot_valid(shot_valid),
        .shot_row(shot_row),
        .shot_col(shot_col),
        .entry_row(entry_row),
        .entry_col(entry_col),
        .entry_stage(entry_stage),
        .key_err(key_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int k;
        k = int'(key_value);
        m_err = 1'b0;
        if (!rst_n) begin
            m_digits.delete();
            m_sending = 1'b0;
            m_shot_r = 0;
            m_shot_c = 0;
            m_idle = 0;
        end else if (m_sending) begin
            if (shot_ready) begin
                m_sending = 1'b0;
                m_digits.delete();
            end
        end else if (!arm) begin
            m_digits.delete();
            m_idle = 0;
        end else if (key_valid) begin
            m_idle = 0;
            if (k <= 9) begin
                if (m_digits.size() < 2 && k < GRID) m_digits.push_back(k);
                else m_err = 1'b1;
            end else if (k == 13) begin
                if (m_digits.size() > 0) void'(m_digits.pop_back());
                else m_err = 1'b1;
            end else if (k == 14) begin
                m_digits.delete();
            end else if (k == 15) begin
                if (m_digits.size() == 2) begin
                    m_sending = 1'b1;
                    m_shot_r = m_digits[0];
                    m_shot_c = m_digits[1];
                end else begin
                    m_err = 1'b1;
                end
            end else begin
                m_err = 1'b1;
            end
        end else if (m_digits.size() > 0) begin
            if (m_idle == TMO - 1) begin
                m_digits.delete();
                m_idle = 0;
            end else begin
                m_idle++;
            end
        end
    endtask

    function automatic int exp_row();
        return (m_digits.size() >= 1) ? m_digits[0] : 15;
    endfunction

    function automatic int exp_col();
        return (m_digits.size() >= 2) ? m_digits[1] : 15;
    endfunction

    function automatic int exp_stage();
        return m_sending ? 3 : m_digits.size();
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("shot_valid", 32'(shot_valid), 32'(m_sending));
            check("shot_row", 32'(shot_row), 32'(m_shot_r));
            check("shot_col", 32'(shot_col), 32'(m_shot_c));
            check("entry_row", 32'(entry_row), 32'(exp_row()));
            check("entry_col", 32'(entry_col), 32'(exp_col()));
            check("entry_stage", 32'(entry_stage), 32'(exp_stage()));
            check("key_err", 32'(key_err), 32'(m_err));
        end
    end

    task automatic step(input logic [3:0] k, input logic kv, input logic a, input logic r);
        key_value = k;
        key_valid = kv;
        arm = a;
        shot_ready = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic key(input logic [3:0] k);
        step(k, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic idle();
        step(4'h0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int n;
        step(4'h0, 1'b0, 1'b1, 1'b0);
        step(4'h0, 1'b0, 1'b1, 1'b0);
        chk_en = 1'b1;
        check("rst_stage", 32'(entry_stage), 32'd0);
        check("rst_row", 32'(entry_row), 32'hF);
        check("rst_valid", 32'(shot_valid), 32'd0);
        rst_n = 1'b1;
        idle();

        // Legal shot with ready already high.
        step(4'h3, 1'b1, 1'b1, 1'b1);
        step(4'h5, 1'b1, 1'b1, 1'b1);
        step(4'hF, 1'b1, 1'b1, 1'b1);
        check("legal_valid", 32'(shot_valid), 32'd1);
        check("legal_row", 32'(shot_row), 32'd3);
        check("legal_col", 32'(shot_col), 32'd5);
        step(4'h0, 1'b0, 1'b1, 1'b1);
        check("legal_drop", 32'(shot_valid), 32'd0);
        check("legal_blank", 32'(entry_row), 32'hF);

        // Backpressure: stray key and arm drop while waiting.
        key(4'h2); key(4'h7); key(4'hF);
        for (int i = 0; i < 20; i++) begin
            step((i == 5) ? 4'h4 : 4'h0, (i == 5), !(i >= 8 && i <= 14), 1'b0);
            check("bp_valid", 32'(shot_valid), 32'd1);
            check("bp_row", 32'(shot_row), 32'd2);
            check("bp_col", 32'(shot_col), 32'd7);
            check("bp_err", 32'(key_err), 32'd0);
        end
        step(4'h0, 1'b0, 1'b1, 1'b1);
        check("bp_done", 32'(shot_valid), 32'd0);
        check("bp_stage", 32'(entry_stage), 32'd0);

        // Illegal keys in each entry state.
        key(4'h9);
        check("ill_row_err", 32'(key_err), 32'd1);
        check("ill_row_stage", 32'(entry_stage), 32'd0);
        idle();
        check("ill_err_pulse", 32'(key_err), 32'd0);
        key(4'h3); key(4'hF);
        check("ill_col_err", 32'(key_err), 32'd1);
        check("ill_col_row", 32'(entry_row), 32'd3);
        key(4'h1); key(4'h1);
        check("ill_ent_err", 32'(key_err), 32'd1);
        check("ill_ent_stage", 32'(entry_stage), 32'd2);
        key(4'hE);

        // Edit keys.
        key(4'h4); key(4'h6); key(4'hD);
        check("bksp_col", 32'(entry_col), 32'hF);
        check("bksp_stage", 32'(entry_stage), 32'd1);
        key(4'h2); key(4'hE);
        check("clr_row", 32'(entry_row), 32'hF);
        check("clr_stage", 32'(entry_stage), 32'd0);

        // Timeout length, then a key landing in the expiry cycle.
        key(4'h5);
        n = 0;
        while (entry_stage != 2'd0 && n < 40) begin
            idle();
            n++;
        end
        check("tmo_cycles", 32'(n), 32'd16);
        key(4'h5);
        for (int i = 0; i < 15; i++) idle();
        key(4'h2);
        check("tmo_key_wins", 32'(entry_stage), 32'd2);
        check("tmo_key_col", 32'(entry_col), 32'd2);
        key(4'hE);

        // Reset mid-entry, then a key while disarmed.
        key(4'h1); key(4'h2);
        rst_n = 1'b0;
        idle();
        check("rst_mid_stage", 32'(entry_stage), 32'd0);
        check("rst_mid_col", 32'(entry_col), 32'hF);
        rst_n = 1'b1;
        step(4'h3, 1'b1, 1'b0, 1'b0);
        check("disarm_stage", 32'(entry_stage), 32'd0);
        check("disarm_err", 32'(key_err), 32'd0);

        // Randomized traffic with quiet phases so timeouts occur.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] k;
            logic       kv;
            k = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 15));
            if (((i / 100) % 3) == 2) kv = ($urandom_range(0, 39) == 0);
            else kv = ($urandom_range(0, 2) == 0);
            rst_n = ($urandom_range(0, 499) != 0);
            step(k, kv, ($urandom_range(0, 19) != 0), ($urandom_range(0, 3) == 0));
        end
        rst_n = 1'b1;
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
